// File: rtl/seq_divide.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with divide-by-zero flagged instead of iterated.
module seq_divide #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] partRem_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;
  logic             divZero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   shiftRem;
  logic             trialFits;
  logic [WIDTH-1:0] partRem_d;
  logic [WIDTH-1:0] work_d;

  // The partial remainder is always below the divisor, so the wrapped
  // WIDTH-bit difference is exact whenever the trial subtract succeeds.
  always_comb begin
    shiftRem  = {partRem_q, work_q[WIDTH-1]};
    trialFits = shiftRem[WIDTH] || (shiftRem[WIDTH-1:0] >= divisor_q);
    partRem_d = shiftRem[WIDTH-1:0];
    work_d    = {work_q[WIDTH-2:0], 1'b0};
    if (trialFits) begin
      partRem_d = shiftRem[WIDTH-1:0] - divisor_q;
      work_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      partRem_q   <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divZero_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (start_i) begin
            if (divisor_i == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              divZero_q   <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend_i;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              count_q   <= '0;
              partRem_q <= '0;
              work_q    <= dividend_i;
              divisor_q <= divisor_i;
            end
          end
        end
        RUN: begin
          partRem_q <= partRem_d;
          work_q    <= work_d;
          count_q   <= count_q + CW'(1);
          if (count_q == LAST_ITER) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            divZero_q   <= 1'b0;
            quotient_q  <= work_d;
            remainder_q <= partRem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = divZero_q;

endmodule

// File: tb/tb_seq_divide.sv
// Randomised self-checking bench for seq_divide against an arithmetic
// reference (plain / and %), including handshake timing and abort cases.
module tb_seq_divide;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;

  int vecCount  = 0;
  int missCount = 0;

  logic [W-1:0] heldQ;
  logic [W-1:0] heldR;
  logic         heldDz;

  always #5 clk_i = ~clk_i;

  seq_divide #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called #1 after an edge; starts a division and follows it to its done cycle.
  // injectAt >= 0 pulses a spurious start (50/5) at that busy cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int injectAt);
    logic [W-1:0] expQ;
    logic [W-1:0] expR;
    if (b == '0) begin
      expQ = '1;
      expR = a;
    end else begin
      expQ = a / b;
      expR = a % b;
    end
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    dividend_i = W'($urandom);
    divisor_i  = W'($urandom);
    if (b != '0) begin
      for (int i = 0; i < W; i++) begin
        if (i > 0) begin
          @(posedge clk_i); #1;
        end
        checkOutput("busy_run", busy_o, 1);
        checkOutput("done_run", done_o, 0);
        checkOutput("q_hold", quotient_o, heldQ);
        checkOutput("r_hold", remainder_o, heldR);
        start_i = (i == injectAt);
        if (i == injectAt) begin
          dividend_i = 8'd50;
          divisor_i  = 8'd5;
        end
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    checkOutput("done", done_o, 1);
    checkOutput("busy_done", busy_o, 0);
    checkOutput("div_zero", div_zero_o, (b == '0));
    checkOutput("quotient", quotient_o, expQ);
    checkOutput("remainder", remainder_o, expR);
    if (b != '0) begin
      checkOutput("invariant", int'(quotient_o) * int'(b) + int'(remainder_o), int'(a));
      checkOutput("rem_lt_div", (remainder_o < b), 1);
    end
    heldQ  = expQ;
    heldR  = expR;
    heldDz = (b == '0);
  endtask

  task automatic idleCycle();
    @(posedge clk_i); #1;
    checkOutput("done_clear", done_o, 0);
    checkOutput("busy_idle", busy_o, 0);
    checkOutput("q_idle", quotient_o, heldQ);
    checkOutput("r_idle", remainder_o, heldR);
    checkOutput("dz_idle", div_zero_o, heldDz);
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    heldQ      = '0;
    heldR      = '0;
    heldDz     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_q", quotient_o, 0);
    checkOutput("rst_r", remainder_o, 0);
    checkOutput("rst_dz", div_zero_o, 0);
    rst_i = 1'b0;
    idleCycle();

    applyStimulus(8'd100, 8'd7, -1);
    idleCycle();
    applyStimulus(8'd255, 8'd1, -1);
    idleCycle();
    applyStimulus(8'd5, 8'd9, -1);
    idleCycle();
    applyStimulus(8'd0, 8'd3, -1);
    idleCycle();
    applyStimulus(8'd255, 8'd255, -1);
    idleCycle();
    applyStimulus(8'd200, 8'd0, -1);
    idleCycle();

    // Spurious start while busy must not disturb the running division.
    applyStimulus(8'd100, 8'd7, 3);
    idleCycle();

    // Reset part-way through aborts the division and clears the results.
    start_i    = 1'b1;
    dividend_i = 8'd100;
    divisor_i  = 8'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i  = 1'b0;
    heldQ  = '0;
    heldR  = '0;
    heldDz = 1'b0;
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_done", done_o, 0);
    checkOutput("abort_q", quotient_o, 0);
    checkOutput("abort_r", remainder_o, 0);
    checkOutput("abort_dz", div_zero_o, 0);
    idleCycle();
    applyStimulus(8'd9, 8'd2, -1);
    idleCycle();

    // Back-to-back: new start issued in the done cycle, including a zero divisor.
    applyStimulus(8'd77, 8'd6, -1);
    applyStimulus(8'd143, 8'd11, -1);
    applyStimulus(8'd42, 8'd0, -1);
    applyStimulus(8'd250, 8'd13, -1);
    idleCycle();

    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      applyStimulus(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
